jump_ptr_encoder: RTL

Reverse lookup for the processor's jump table. The block holds a writable 32-entry table of 12-bit jump targets and, given a target address, scans it sequentially to return the 5-bit jump pointer that selects that target. It sits beside the assembler/debug load path. Loader logic writes the table and calls this block to encode an absolute branch target into the pointer field of a jump instruction.

---
 rtl/jlut_pkg.sv | 19 +
 rtl/jlut_table.sv | 36 +++
 rtl/jump_ptr_encoder.sv | 99 +++++++++
 3 files changed

// File: rtl/jlut_pkg.sv
// Shared constants and types for the jump-table reverse lookup.
package jlut_pkg;

  localparam int unsigned PTR_W   = 5;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned ENTRIES = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } enc_state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } entry_t;

endpackage

// File: rtl/jlut_table.sv
// Jump-table storage: synchronous write port, one combinational read port.
module jlut_table #(
  parameter int unsigned PTR_W   = 5,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned ENTRIES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PTR_W-1:0]  rd_ptr,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr
);

  logic [ENTRIES-1:0] valid_q;
  logic [ADDR_W-1:0]  addr_q [ENTRIES];

  // Reset clears the whole table so a reset mid-search leaves nothing stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        addr_q[i] <= '0;
      end
    end else if (wr_en) begin
      valid_q[wr_ptr] <= 1'b1;
      addr_q[wr_ptr]  <= wr_addr;
    end
  end

  assign rd_valid = valid_q[rd_ptr];
  assign rd_addr  = addr_q[rd_ptr];

endmodule

// File: rtl/jump_ptr_encoder.sv
// Sequential reverse lookup: scans the jump table for Target, returns lowest matching pointer.
module jump_ptr_encoder #(
  parameter int unsigned PTR_W   = jlut_pkg::PTR_W,
  parameter int unsigned ADDR_W  = jlut_pkg::ADDR_W,
  parameter int unsigned ENTRIES = jlut_pkg::ENTRIES
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              WrEn,
  input  logic [PTR_W-1:0]  WrPtr,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Target,
  output logic              Busy,
  output logic              Done,
  output logic              Hit,
  output logic [PTR_W-1:0]  Jptr
);

  import jlut_pkg::*;

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(ENTRIES - 1);

  enc_state_t        state;
  logic [PTR_W-1:0]  idx;
  logic [ADDR_W-1:0] target_q;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic              match_c;

  jlut_table #(
    .PTR_W   (PTR_W),
    .ADDR_W  (ADDR_W),
    .ENTRIES (ENTRIES)
  ) u_table (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .wr_en    (WrEn),
    .wr_ptr   (WrPtr),
    .wr_addr  (WrAddr),
    .rd_ptr   (idx),
    .rd_valid (rd_valid),
    .rd_addr  (rd_addr)
  );

  // Invalid entries never match, even against a zero target.
  assign match_c = rd_valid && (rd_addr == target_q);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      target_q <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Hit      <= 1'b0;
      Jptr     <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            target_q <= Target;
            idx      <= '0;
            Hit      <= 1'b0;
            Jptr     <= '0;
            Busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (match_c) begin
            Hit   <= 1'b1;
            Jptr  <= idx;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= FIN;
          end else if (idx == LAST_IDX) begin
            Hit   <= 1'b0;
            Jptr  <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= FIN;
          end else begin
            idx <= idx + PTR_W'(1);
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
